clock_reset_manager: RTL and testbench

Parametrised clock/reset generator for FPGA top-level wrappers. It replaces the fixed divide-by-2 toggle and single-pulse boot reset with four pieces:
- an integer clock divider with both a divided clock and a clock-enable strobe;
- a boot reset stretcher;
- a debounced external reset input plus a synchronous soft-reset request;
- a staggered release of NUM_RESETS reset outputs.

It sits between the board clock/button pins and the Controller and core reset inputs.

---
 rtl/clock_reset_pkg.sv | 22 ++
 rtl/reset_debouncer.sv | 51 +++++
 rtl/clock_reset_manager.sv | 173 +++++++++++++++++
 tb/tb_clock_reset_manager.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_reset_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_reset_pkg
//  Purpose  : Shared state encoding and helpers for clock_reset_manager.
//  Revision : 1.0 - initial release
// ============================================================================
package clock_reset_pkg;

    // Reset sequencer state encoding
    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STAGGER = 2'd1,
        RUN     = 2'd2
    } state_t;

    // Larger of two integers; sizes the shared hold/stagger counter
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : reset_debouncer
//  Purpose  : Two-flop synchroniser and saturating low-level debouncer for the
//             asynchronous active-low board reset button.
//  Revision : 1.0 - initial release
// ============================================================================
module reset_debouncer
    import clock_reset_pkg::*;
#(
    parameter int DEBOUNCE = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic ext_reset_n,
    output logic ext_req
);

    localparam int              CW        = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]   C_DEB_MAX = CW'(DEBOUNCE);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;

    // Bring the button into the clk domain; idle (released) level is 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= ext_reset_n;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive low samples, saturating; any high sample restarts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_sync2) begin
            r_cnt <= '0;
        end else if (r_cnt != C_DEB_MAX) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign ext_req = (r_cnt == C_DEB_MAX);

endmodule
`default_nettype wire

// File: rtl/clock_reset_manager.sv
`default_nettype none
// ============================================================================
//  Module   : clock_reset_manager
//  Purpose  : Integer clock divider (divided clock + enable strobe), boot and
//             request reset stretcher, and staggered release of NUM_RESETS
//             active-high reset outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module clock_reset_manager #(
    parameter int DIV        = 2,
    parameter int CYCLES     = 20,
    parameter int NUM_RESETS = 2,
    parameter int STAGGER    = 4,
    parameter int DEBOUNCE   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ext_reset_n,
    input  logic                  soft_reset_req,
    output logic                  clk_div,
    output logic                  clk_en,
    output logic [NUM_RESETS-1:0] reset_o,
    output logic                  ready
);
    import clock_reset_pkg::*;

    localparam int              DW         = $clog2(DIV);
    localparam logic [DW-1:0]   C_DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0]   C_DIV_HALF = DW'(DIV / 2 - 1);

    localparam int              CW         = $clog2(max2(CYCLES, STAGGER) + 1);
    localparam logic [CW-1:0]   C_CYC_LAST = CW'(CYCLES - 1);
    localparam logic [CW-1:0]   C_STG_LAST = CW'(STAGGER - 1);
    localparam int              IW         = $clog2(NUM_RESETS + 1);

    logic [DW-1:0]         r_div_cnt;
    logic                  r_clk_div;
    logic                  r_clk_en;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [IW-1:0]         r_idx;
    logic [IW-1:0]         w_idx_nxt;
    logic [NUM_RESETS-1:0] r_reset_o;
    logic [NUM_RESETS-1:0] w_reset_o_nxt;
    logic                  r_ready;
    logic                  w_ready_nxt;

    logic                  w_ext_req;
    logic                  w_req;

    reset_debouncer #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debouncer (
        .clk         (clk),
        .reset       (reset),
        .ext_reset_n (ext_reset_n),
        .ext_req     (w_ext_req)
    );

    assign w_req = w_ext_req | soft_reset_req;

    // Free-running divider; phase depends only on the block reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_clk_div <= 1'b0;
            r_clk_en  <= 1'b0;
        end else begin
            r_clk_en <= (r_div_cnt == C_DIV_LAST);
            if (r_div_cnt == C_DIV_LAST) begin
                r_div_cnt <= '0;
                r_clk_div <= 1'b0;
            end else begin
                r_div_cnt <= r_div_cnt + DW'(1);
                if (r_div_cnt == C_DIV_HALF) begin
                    r_clk_div <= 1'b1;
                end
            end
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= HOLD;
            r_cnt     <= '0;
            r_idx     <= IW'(1);
            r_reset_o <= '1;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_reset_o <= w_reset_o_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    // Sequencer next state: any request restarts the hold phase
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_reset_o_nxt = r_reset_o;
        w_ready_nxt   = r_ready;

        if (w_req) begin
            w_state_nxt   = HOLD;
            w_cnt_nxt     = '0;
            w_idx_nxt     = IW'(1);
            w_reset_o_nxt = '1;
            w_ready_nxt   = 1'b0;
        end else begin
            case (r_state)
                HOLD: begin
                    w_reset_o_nxt = '1;
                    w_ready_nxt   = 1'b0;
                    if (r_cnt == C_CYC_LAST) begin
                        w_cnt_nxt        = '0;
                        w_idx_nxt        = IW'(1);
                        w_reset_o_nxt[0] = 1'b0;
                        if (NUM_RESETS == 1) begin
                            w_state_nxt = RUN;
                            w_ready_nxt = 1'b1;
                        end else begin
                            w_state_nxt = clock_reset_pkg::STAGGER;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                clock_reset_pkg::STAGGER: begin
                    if (r_cnt == C_STG_LAST) begin
                        w_cnt_nxt = '0;
                        for (int i = 0; i < NUM_RESETS; i++) begin
                            if (i == int'(r_idx)) begin
                                w_reset_o_nxt[i] = 1'b0;
                            end
                        end
                        if (int'(r_idx) == NUM_RESETS - 1) begin
                            w_state_nxt = RUN;
                            w_ready_nxt = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + IW'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                RUN: begin
                    w_reset_o_nxt = '0;
                    w_ready_nxt   = 1'b1;
                end
                default: begin
                    w_state_nxt   = HOLD;
                    w_cnt_nxt     = '0;
                    w_reset_o_nxt = '1;
                    w_ready_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign clk_div = r_clk_div;
    assign clk_en  = r_clk_en;
    assign reset_o = r_reset_o;
    assign ready   = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_clock_reset_manager.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_reset_manager
//  Purpose  : Scoreboard bench driving three differently parameterised
//             clock_reset_manager instances from shared inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clock_reset_manager;

    localparam int NCFG = 3;
    localparam int P_DIV [NCFG] = '{2, 5, 4};
    localparam int P_CYC [NCFG] = '{20, 1, 20};
    localparam int P_NR  [NCFG] = '{2, 1, 4};
    localparam int P_STG [NCFG] = '{4, 4, 1};
    localparam int P_DEB [NCFG] = '{3, 3, 2};

    typedef struct packed {
        logic [3:0] ro;
        logic       rdy;
        logic       cdiv;
        logic       cen;
    } exp_t;
    typedef exp_t [NCFG-1:0] exp3_t;

    logic clk            = 1'b0;
    logic reset          = 1'b1;
    logic ext_reset_n    = 1'b1;
    logic soft_reset_req = 1'b0;
    logic async_chk      = 1'b0;

    logic [NCFG-1:0] clk_div_v;
    logic [NCFG-1:0] clk_en_v;
    logic [NCFG-1:0] ready_v;
    logic [1:0]      ro0;
    logic [0:0]      ro1;
    logic [3:0]      ro2;
    logic [3:0]      ro_v [NCFG];

    int checks = 0;
    int errors = 0;

    exp3_t sb_q [$];

    assign ro_v[0] = {2'b00, ro0};
    assign ro_v[1] = {3'b000, ro1};
    assign ro_v[2] = ro2;

    always #5 clk = ~clk;

    clock_reset_manager #(
        .DIV(P_DIV[0]), .CYCLES(P_CYC[0]), .NUM_RESETS(P_NR[0]),
        .STAGGER(P_STG[0]), .DEBOUNCE(P_DEB[0])
    ) u_dut0 (
        .clk(clk), .reset(reset), .ext_reset_n(ext_reset_n),
        .soft_reset_req(soft_reset_req), .clk_div(clk_div_v[0]),
        .clk_en(clk_en_v[0]), .reset_o(ro0), .ready(ready_v[0])
    );

    clock_reset_manager #(
        .DIV(P_DIV[1]), .CYCLES(P_CYC[1]), .NUM_RESETS(P_NR[1]),
        .STAGGER(P_STG[1]), .DEBOUNCE(P_DEB[1])
    ) u_dut1 (
        .clk(clk), .reset(reset), .ext_reset_n(ext_reset_n),
        .soft_reset_req(soft_reset_req), .clk_div(clk_div_v[1]),
        .clk_en(clk_en_v[1]), .reset_o(ro1), .ready(ready_v[1])
    );

    clock_reset_manager #(
        .DIV(P_DIV[2]), .CYCLES(P_CYC[2]), .NUM_RESETS(P_NR[2]),
        .STAGGER(P_STG[2]), .DEBOUNCE(P_DEB[2])
    ) u_dut2 (
        .clk(clk), .reset(reset), .ext_reset_n(ext_reset_n),
        .soft_reset_req(soft_reset_req), .clk_div(clk_div_v[2]),
        .clk_en(clk_en_v[2]), .reset_o(ro2), .ready(ready_v[2])
    );

    // Reference model: n = edges since block reset, k = request-free edges
    // since the last request; button history holds one sample per edge.
    int   m_n;
    int   m_k [NCFG];
    logic m_hist [8];

    always @(posedge clk) begin
        exp3_t e;
        logic  ext_req;
        e = '0;
        if (reset) begin
            m_n = 0;
            for (int c = 0; c < NCFG; c++) begin
                m_k[c] = 0;
                for (int i = 0; i < P_NR[c]; i++) e[c].ro[i] = 1'b1;
            end
            for (int j = 0; j < 8; j++) m_hist[j] = 1'b1;
        end else begin
            m_n = m_n + 1;
            for (int c = 0; c < NCFG; c++) begin
                // Button request seen by this edge: DEB low samples, two edges old
                ext_req = 1'b1;
                for (int j = 2; j <= P_DEB[c] + 1; j++) begin
                    if (m_hist[j]) ext_req = 1'b0;
                end
                if (soft_reset_req || ext_req) m_k[c] = 0;
                else if (m_k[c] < 10000) m_k[c] = m_k[c] + 1;
                for (int i = 0; i < P_NR[c]; i++) begin
                    e[c].ro[i] = (m_k[c] < P_CYC[c] + i * P_STG[c]);
                end
                e[c].rdy  = (m_k[c] >= P_CYC[c] + (P_NR[c] - 1) * P_STG[c]);
                e[c].cen  = ((m_n % P_DIV[c]) == 0);
                e[c].cdiv = ((m_n % P_DIV[c]) >= P_DIV[c] / 2);
            end
            for (int j = 7; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = ext_reset_n;
        end
        sb_q.push_back(e);
    end

    // Monitor: pop one expectation per cycle; also checks async reset instantly
    always @(negedge clk or posedge async_chk) begin
        exp3_t e;
        exp_t  act;
        if (async_chk) begin
            for (int c = 0; c < NCFG; c++) begin
                act = {ro_v[c], ready_v[c], clk_div_v[c], clk_en_v[c]};
                e[c] = '0;
                for (int i = 0; i < P_NR[c]; i++) e[c].ro[i] = 1'b1;
                checks = checks + 1;
                if (act !== e[c]) begin
                    errors = errors + 1;
                    $display("FAIL async_reset cfg%0d t=%0t got ro=%b rdy=%b div=%b en=%b want ro=%b rdy=%b div=%b en=%b",
                             c, $time, act.ro, act.rdy, act.cdiv, act.cen,
                             e[c].ro, e[c].rdy, e[c].cdiv, e[c].cen);
                end
            end
        end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            for (int c = 0; c < NCFG; c++) begin
                act = {ro_v[c], ready_v[c], clk_div_v[c], clk_en_v[c]};
                checks = checks + 1;
                if (act !== e[c]) begin
                    errors = errors + 1;
                    $display("FAIL outputs cfg%0d t=%0t got ro=%b rdy=%b div=%b en=%b want ro=%b rdy=%b div=%b en=%b",
                             c, $time, act.ro, act.rdy, act.cdiv, act.cen,
                             e[c].ro, e[c].rdy, e[c].cdiv, e[c].cen);
                end
            end
        end
    end

    // Advance n cycles; returns just after a falling edge
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int burst;
        burst = 0;

        // Boot sequence from block reset
        step(3);
        reset = 1'b0;

        // Soft request sampled at edge 23, mid-stagger
        step(22);
        soft_reset_req = 1'b1;
        step(1);
        soft_reset_req = 1'b0;
        step(40);

        // Short button glitch, then a long press
        ext_reset_n = 1'b0;
        step(2);
        ext_reset_n = 1'b1;
        step(40);
        ext_reset_n = 1'b0;
        step(10);
        ext_reset_n = 1'b1;
        step(45);

        // Randomised requests and button bursts
        for (int t = 0; t < 600; t++) begin
            soft_reset_req = ($urandom_range(0, 49) == 0);
            if (burst > 0) begin
                ext_reset_n = 1'b0;
                burst = burst - 1;
            end else begin
                ext_reset_n = 1'b1;
                if ($urandom_range(0, 39) == 0) burst = int'($urandom_range(1, 8));
            end
            step(1);
        end
        soft_reset_req = 1'b0;
        ext_reset_n    = 1'b1;
        step(50);

        // Asynchronous block reset while running
        #1 reset = 1'b1;
        #1 async_chk = 1'b1;
        #1 async_chk = 1'b0;
        step(3);
        reset = 1'b0;
        step(30);

        @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
